// File: rtl/audio_sample_conditioner_if.sv
// Codec-side and output-side signals of audio_sample_conditioner.
//   master : drives readReady / readdataLeft / readdataRight and observes
//            doRead plus the conditioned outputs (codec model / consumer).
//   slave  : the conditioner itself.
//   readReady      codec has a sample pair available
//   readdataLeft   left sample, signed, IN_W bits
//   readdataRight  right sample, signed, IN_W bits
//   doRead         one-cycle pop strobe to the codec
//   sampleOut      conditioned mono sample, signed, N bits
//   sampleValid    one-cycle pulse, sampleOut is new
//   peakAbs        |sampleOut| >> (N-10)
//   clipped        saturation occurred for this output
interface audio_sample_conditioner_if #(
   parameter int IN_W = 24,
   parameter int N    = 16
);
   logic            readReady;
   logic [IN_W-1:0] readdataLeft;
   logic [IN_W-1:0] readdataRight;
   logic            doRead;
   logic [N-1:0]    sampleOut;
   logic            sampleValid;
   logic [9:0]      peakAbs;
   logic            clipped;

   modport master (
      output readReady, readdataLeft, readdataRight,
      input  doRead, sampleOut, sampleValid, peakAbs, clipped
   );

   modport slave (
      input  readReady, readdataLeft, readdataRight,
      output doRead, sampleOut, sampleValid, peakAbs, clipped
   );
endinterface

// File: rtl/audio_sample_conditioner.sv
// Pops stereo pairs from the codec, sums to mono, removes DC with a leaky
// tracker, box-car averages and decimates by DECIM, then saturates to N bits.
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   bus  : audio_sample_conditioner_if.slave (codec read side + outputs)
module audio_sample_conditioner #(
   parameter int IN_W     = 24,
   parameter int N        = 16,
   parameter int DECIM    = 2,
   parameter int DC_SHIFT = 10
) (
   input logic clk,
   input logic rst,
   audio_sample_conditioner_if.slave bus
);
   localparam int LOG2D = $clog2(DECIM);
   localparam int CNT_W = (LOG2D > 0) ? LOG2D : 1;
   localparam int HW    = IN_W + 2;
   localparam int DW    = HW + DC_SHIFT;
   localparam int AW    = HW + LOG2D;

   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DECIM - 1);
   localparam logic signed [N+1:0] Y_MAX = {3'b000, {(N-1){1'b1}}};
   localparam logic signed [N+1:0] Y_MIN = {3'b111, {(N-1){1'b0}}};

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_FILT  = 2'd2;
   localparam logic [1:0] S_ACCUM = 2'd3;

   logic [1:0]            state_q,     state_d;
   logic [IN_W-1:0]       left_q,      left_d;
   logic [IN_W-1:0]       right_q,     right_d;
   logic signed [HW-1:0]  hp_q,        hp_d;
   logic signed [DW-1:0]  dcAcc_q,     dcAcc_d;
   logic signed [AW-1:0]  acc_q,       acc_d;
   logic [CNT_W-1:0]      cnt_q,       cnt_d;
   logic [N-1:0]          sampleOut_q, sampleOut_d;
   logic [9:0]            peakAbs_q,   peakAbs_d;
   logic                  valid_q,     valid_d;
   logic                  clipped_q,   clipped_d;

   logic signed [IN_W:0]  mono;
   logic signed [HW-1:0]  dc;
   logic signed [HW-1:0]  hp;
   logic signed [AW-1:0]  acc_sum;
   logic signed [N+1:0]   y;
   logic [N-1:0]          sat;
   logic                  clip;
   logic [N-1:0]          mag;

   always_comb begin
      mono    = $signed({left_q[IN_W-1], left_q}) + $signed({right_q[IN_W-1], right_q});
      // Top HW bits of the tracker are exactly dcAcc >>> DC_SHIFT.
      dc      = $signed(dcAcc_q[DW-1:DC_SHIFT]);
      hp      = $signed({mono[IN_W], mono}) - dc;
      acc_sum = acc_q + AW'(hp_q);
      // Dropping LOG2D + (IN_W-N) low bits performs both arithmetic shifts
      // (average, then width reduction); N+2 bits keep the full range.
      y       = $signed(acc_sum[AW-1:LOG2D+IN_W-N]);
      clip    = 1'b0;
      if (y > Y_MAX) begin
         sat  = Y_MAX[N-1:0];
         clip = 1'b1;
      end else if (y < Y_MIN) begin
         sat  = Y_MIN[N-1:0];
         clip = 1'b1;
      end else begin
         sat  = y[N-1:0];
      end
      // Two's-complement magnitude as unsigned N bits: -2^(N-1) -> 2^(N-1).
      mag = sat[N-1] ? (~sat + 1'b1) : sat;
   end

   always_comb begin
      state_d     = state_q;
      left_d      = left_q;
      right_d     = right_q;
      hp_d        = hp_q;
      dcAcc_d     = dcAcc_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      sampleOut_d = sampleOut_q;
      peakAbs_d   = peakAbs_q;
      valid_d     = 1'b0;
      clipped_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.readReady) state_d = S_READ;
         end
         S_READ: begin
            left_d  = bus.readdataLeft;
            right_d = bus.readdataRight;
            state_d = S_FILT;
         end
         S_FILT: begin
            hp_d    = hp;
            dcAcc_d = dcAcc_q + DW'(hp);
            state_d = S_ACCUM;
         end
         default: begin
            if (cnt_q == CNT_LAST) begin
               acc_d       = '0;
               cnt_d       = '0;
               sampleOut_d = sat;
               peakAbs_d   = 10'(mag >> (N - 10));
               clipped_d   = clip;
               valid_d     = 1'b1;
            end else begin
               acc_d = acc_sum;
               cnt_d = cnt_q + 1'b1;
            end
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         left_q      <= '0;
         right_q     <= '0;
         hp_q        <= '0;
         dcAcc_q     <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         sampleOut_q <= '0;
         peakAbs_q   <= '0;
         valid_q     <= 1'b0;
         clipped_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         left_q      <= left_d;
         right_q     <= right_d;
         hp_q        <= hp_d;
         dcAcc_q     <= dcAcc_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         sampleOut_q <= sampleOut_d;
         peakAbs_q   <= peakAbs_d;
         valid_q     <= valid_d;
         clipped_q   <= clipped_d;
      end
   end

   assign bus.doRead      = (state_q == S_READ);
   assign bus.sampleOut   = sampleOut_q;
   assign bus.peakAbs     = peakAbs_q;
   assign bus.sampleValid = valid_q;
   assign bus.clipped     = clipped_q;
endmodule

// File: tb/tb_audio_sample_conditioner.sv
module tb_audio_sample_conditioner;
   logic clk;
   logic rst;
   int   passed;
   int   total;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A: DECIM=2 DC_SHIFT=10, B: DECIM=1 DC_SHIFT=4,
   // C: DECIM=1 DC_SHIFT=20, D: DECIM=4 DC_SHIFT=20
   audio_sample_conditioner_if #(.IN_W(24), .N(16)) ifA ();
   audio_sample_conditioner_if #(.IN_W(24), .N(16)) ifB ();
   audio_sample_conditioner_if #(.IN_W(24), .N(16)) ifC ();
   audio_sample_conditioner_if #(.IN_W(24), .N(16)) ifD ();

   audio_sample_conditioner #(.IN_W(24), .N(16), .DECIM(2), .DC_SHIFT(10))
      dutA (.clk(clk), .rst(rst), .bus(ifA.slave));
   audio_sample_conditioner #(.IN_W(24), .N(16), .DECIM(1), .DC_SHIFT(4))
      dutB (.clk(clk), .rst(rst), .bus(ifB.slave));
   audio_sample_conditioner #(.IN_W(24), .N(16), .DECIM(1), .DC_SHIFT(20))
      dutC (.clk(clk), .rst(rst), .bus(ifC.slave));
   audio_sample_conditioner #(.IN_W(24), .N(16), .DECIM(4), .DC_SHIFT(20))
      dutD (.clk(clk), .rst(rst), .bus(ifD.slave));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      ifA.readReady = 1'b0; ifB.readReady = 1'b0;
      ifC.readReady = 1'b0; ifD.readReady = 1'b0;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      total++; if (ifA.doRead !== 1'b0) $display("FAIL reset_doRead: got %b expected 0", ifA.doRead); else passed++;
      total++; if (ifA.sampleValid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", ifA.sampleValid); else passed++;
      total++; if (ifA.sampleOut !== 16'd0) $display("FAIL reset_sampleOut: got %0h expected 0", ifA.sampleOut); else passed++;
      total++; if (ifA.peakAbs !== 10'd0) $display("FAIL reset_peakAbs: got %0d expected 0", ifA.peakAbs); else passed++;
      total++; if (ifC.clipped !== 1'b0) $display("FAIL reset_clipped: got %b expected 0", ifC.clipped); else passed++;
      rst = 1'b0;
   endtask

   task automatic test_idle();
      int reads = 0;
      int valids = 0;
      int nonzero = 0;
      do_reset();
      ifA.readdataLeft = 24'h123456; ifA.readdataRight = 24'h654321;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (ifA.doRead !== 1'b0) reads++;
         if (ifA.sampleValid !== 1'b0) valids++;
         if (ifA.sampleOut !== 16'd0 || ifA.peakAbs !== 10'd0 || ifA.clipped !== 1'b0) nonzero++;
      end
      total++; if (reads != 0) $display("FAIL idle_doRead: got %0d pulses expected 0", reads); else passed++;
      total++; if (valids != 0) $display("FAIL idle_valid: got %0d pulses expected 0", valids); else passed++;
      total++; if (nonzero != 0) $display("FAIL idle_outputs: got %0d nonzero cycles expected 0", nonzero); else passed++;
   endtask

   task automatic test_stream_zeros();
      int n = 0;
      int readErr = 0;
      int validErr = 0;
      int dataErr = 0;
      int nvalid = 0;
      do_reset();
      ifA.readdataLeft = '0; ifA.readdataRight = '0;
      ifA.readReady = 1'b1;
      while (ifA.doRead !== 1'b1 && n < 20) begin tick(); n++; end
      total++; if (ifA.doRead !== 1'b1) $display("FAIL stream_first_read: got %b expected 1", ifA.doRead); else passed++;
      for (int k = 0; k < 64; k++) begin
         if (ifA.doRead !== ((k % 4) == 0)) readErr++;
         if (ifA.sampleValid !== ((k % 8) == 7)) validErr++;
         if (ifA.sampleValid === 1'b1) begin
            nvalid++;
            if (ifA.sampleOut !== 16'd0 || ifA.peakAbs !== 10'd0 || ifA.clipped !== 1'b0) dataErr++;
         end
         tick();
      end
      ifA.readReady = 1'b0;
      total++; if (readErr != 0) $display("FAIL stream_read_period: got %0d misplaced cycles expected 0", readErr); else passed++;
      total++; if (validErr != 0) $display("FAIL stream_valid_period: got %0d misplaced cycles expected 0", validErr); else passed++;
      total++; if (nvalid != 8) $display("FAIL stream_valid_count: got %0d expected 8", nvalid); else passed++;
      total++; if (dataErr != 0) $display("FAIL stream_zero_data: got %0d nonzero outputs expected 0", dataErr); else passed++;
   endtask

   task automatic test_dc_removal();
      int vals[40];
      int n = 0;
      int cyc = 0;
      int nonmono = 0;
      do_reset();
      ifB.readdataLeft = 24'h000100; ifB.readdataRight = 24'h000100;
      ifB.readReady = 1'b1;
      while (n < 40 && cyc < 400) begin
         tick(); cyc++;
         if (ifB.sampleValid === 1'b1) begin
            vals[n] = $signed(ifB.sampleOut);
            n++;
         end
      end
      ifB.readReady = 1'b0;
      for (int i = 1; i < n; i++) if (vals[i] > vals[i-1]) nonmono++;
      total++; if (n != 40) $display("FAIL dc_count: got %0d outputs expected 40", n); else passed++;
      total++; if (vals[0] != 2) $display("FAIL dc_first: got %0d expected 2", vals[0]); else passed++;
      total++; if (vals[1] != 1) $display("FAIL dc_second: got %0d expected 1", vals[1]); else passed++;
      total++; if (nonmono != 0) $display("FAIL dc_monotonic: got %0d increases expected 0", nonmono); else passed++;
      total++; if (vals[39] != 0 || vals[30] != 0) $display("FAIL dc_settled: got %0d/%0d expected 0/0", vals[30], vals[39]); else passed++;
   endtask

   task automatic test_saturation();
      int n;
      // positive full scale
      do_reset();
      ifC.readdataLeft = 24'h7FFFFF; ifC.readdataRight = 24'h7FFFFF;
      ifC.readReady = 1'b1;
      n = 0;
      while (ifC.sampleValid !== 1'b1 && n < 20) begin tick(); n++; end
      total++; if (ifC.sampleValid !== 1'b1) $display("FAIL sat_pos_valid: got %b expected 1", ifC.sampleValid); else passed++;
      total++; if (ifC.sampleOut !== 16'h7FFF) $display("FAIL sat_pos_out: got %0h expected 7fff", ifC.sampleOut); else passed++;
      total++; if (ifC.clipped !== 1'b1) $display("FAIL sat_pos_clip: got %b expected 1", ifC.clipped); else passed++;
      total++; if (ifC.peakAbs !== 10'd511) $display("FAIL sat_pos_peak: got %0d expected 511", ifC.peakAbs); else passed++;
      tick();
      total++; if (ifC.clipped !== 1'b0 || ifC.sampleValid !== 1'b0) $display("FAIL sat_clip_pulse: got clip=%b valid=%b expected 0/0", ifC.clipped, ifC.sampleValid); else passed++;
      total++; if (ifC.sampleOut !== 16'h7FFF) $display("FAIL sat_hold: got %0h expected 7fff", ifC.sampleOut); else passed++;
      // negative full scale
      do_reset();
      ifC.readdataLeft = 24'h800000; ifC.readdataRight = 24'h800000;
      ifC.readReady = 1'b1;
      n = 0;
      while (ifC.sampleValid !== 1'b1 && n < 20) begin tick(); n++; end
      ifC.readReady = 1'b0;
      total++; if (ifC.sampleValid !== 1'b1) $display("FAIL sat_neg_valid: got %b expected 1", ifC.sampleValid); else passed++;
      total++; if (ifC.sampleOut !== 16'h8000) $display("FAIL sat_neg_out: got %0h expected 8000", ifC.sampleOut); else passed++;
      total++; if (ifC.clipped !== 1'b1) $display("FAIL sat_neg_clip: got %b expected 1", ifC.clipped); else passed++;
      total++; if (ifC.peakAbs !== 10'd512) $display("FAIL sat_neg_peak: got %0d expected 512", ifC.peakAbs); else passed++;
   endtask

   task automatic test_averaging();
      int cyc = 0;
      int reads = 0;
      int lastReadCyc = 0;
      logic prevRead = 1'b0;
      logic got = 1'b0;
      do_reset();
      ifD.readdataLeft = 24'h000200; ifD.readdataRight = 24'h000200;
      ifD.readReady = 1'b1;
      while (!got && cyc < 60) begin
         tick(); cyc++;
         // the pair was latched at the edge ending READ; present the next one
         if (prevRead) begin
            ifD.readdataLeft  = (ifD.readdataLeft == 24'h000200) ? 24'h000600 : 24'h000200;
            ifD.readdataRight = ifD.readdataLeft;
         end
         prevRead = ifD.doRead;
         if (ifD.doRead === 1'b1) begin reads++; lastReadCyc = cyc; end
         if (ifD.sampleValid === 1'b1) got = 1'b1;
      end
      ifD.readReady = 1'b0;
      total++; if (got !== 1'b1) $display("FAIL avg_valid: got %b expected 1", got); else passed++;
      total++; if (reads != 4) $display("FAIL avg_reads: got %0d expected 4", reads); else passed++;
      total++; if (cyc - lastReadCyc != 3) $display("FAIL avg_latency: got %0d expected 3", cyc - lastReadCyc); else passed++;
      total++; if (ifD.sampleOut !== 16'd8) $display("FAIL avg_out: got %0d expected 8", $signed(ifD.sampleOut)); else passed++;
      total++; if (ifD.clipped !== 1'b0 || ifD.peakAbs !== 10'd0) $display("FAIL avg_flags: got clip=%b peak=%0d expected 0/0", ifD.clipped, ifD.peakAbs); else passed++;
   endtask

   task automatic test_reset_mid();
      int cyc = 0;
      int reads = 0;
      int readsAtValid = -1;
      logic got = 1'b0;
      do_reset();
      ifA.readdataLeft = 24'h001000; ifA.readdataRight = 24'h001000;
      ifA.readReady = 1'b1;
      // one full group first so the held outputs are nonzero
      while (reads < 4 && cyc < 40) begin
         tick(); cyc++;
         if (ifA.doRead === 1'b1) reads++;
         if (ifA.sampleValid === 1'b1) got = 1'b1;
      end
      total++; if (got !== 1'b1 || ifA.sampleOut !== 16'd31) $display("FAIL mid_pre_out: got valid=%b out=%0d expected 1/31", got, $signed(ifA.sampleOut)); else passed++;
      tick(); // FILT of the second sample of the group
      #2 rst = 1'b1;
      #1;
      total++; if (ifA.sampleOut !== 16'd0) $display("FAIL mid_async_out: got %0d expected 0", $signed(ifA.sampleOut)); else passed++;
      total++; if (ifA.sampleValid !== 1'b0 || ifA.doRead !== 1'b0) $display("FAIL mid_async_strobes: got valid=%b read=%b expected 0/0", ifA.sampleValid, ifA.doRead); else passed++;
      tick(); tick();
      rst = 1'b0;
      reads = 0; cyc = 0; got = 1'b0;
      while (!got && cyc < 40) begin
         tick(); cyc++;
         if (ifA.doRead === 1'b1) reads++;
         if (ifA.sampleValid === 1'b1) begin got = 1'b1; readsAtValid = reads; end
      end
      ifA.readReady = 1'b0;
      total++; if (readsAtValid != 2) $display("FAIL mid_reads_before_valid: got %0d expected 2", readsAtValid); else passed++;
      total++; if (ifA.sampleOut !== 16'd31) $display("FAIL mid_post_out: got %0d expected 31", $signed(ifA.sampleOut)); else passed++;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      rst = 1'b1;
      ifA.readReady = 1'b0; ifB.readReady = 1'b0; ifC.readReady = 1'b0; ifD.readReady = 1'b0;
      ifA.readdataLeft = '0; ifA.readdataRight = '0;
      ifB.readdataLeft = '0; ifB.readdataRight = '0;
      ifC.readdataLeft = '0; ifC.readdataRight = '0;
      ifD.readdataLeft = '0; ifD.readdataRight = '0;
      test_reset();
      test_idle();
      test_stream_zeros();
      test_dc_removal();
      test_saturation();
      test_averaging();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/audio_sample_conditioner.md
Name: audio_sample_conditioner

Overview:
Sits between the audio codec read interface and the DFT input. It pops stereo samples from the codec with a single-cycle read strobe and sums left and right to mono. It removes DC with a first-order leaky tracker, then box-car averages and decimates by DECIM. It emits a saturated N-bit signed sample with a one-cycle valid pulse, plus a 10-bit magnitude for LED metering and a clip flag.

Parameters:
IN_W, 24, codec sample width per channel (signed).
N, 16, output sample width (signed); must satisfy 10 <= N <= IN_W.
DECIM, 2, decimation factor; power of two, 1..64; LOG2D = log2(DECIM).
DC_SHIFT, 10, DC tracker time constant as a shift amount, 1..24.

Ports:
clk  in  1  system clock.
rst  in  1  reset; asynchronous, active-high.
readReady  in  1  codec has a sample pair available.
readdataLeft  in  IN_W  left sample, signed.
readdataRight  in  IN_W  right sample, signed.
doRead  out  1  one-cycle pop strobe to the codec.
sampleOut  out  N  conditioned mono sample, signed.
sampleValid  out  1  one-cycle pulse: sampleOut is new.
peakAbs  out  10  |sampleOut| >> (N-10), updated with sampleValid.
clipped  out  1  high for the sampleValid cycle if saturation occurred.

Behaviour:
- One clock domain; rst is asynchronous and active-high.
- While rst is high: state=IDLE; doRead, sampleValid, clipped, sampleOut, peakAbs, accumulator, decimation count and DC accumulator are all 0.
- FSM, IDLE -> READ -> FILT -> ACCUM -> IDLE:
  - IDLE: if readReady=1, go to READ; otherwise stay.
  - READ: doRead=1 for exactly this cycle; latch readdataLeft/readdataRight into registers.
  - FILT:
    - mono = sext(L) + sext(R), width IN_W+1.
    - dc = dcAcc >>> DC_SHIFT.
    - hp = mono - dc, width IN_W+2.
    - dcAcc <= dcAcc + hp; dcAcc is IN_W+2+DC_SHIFT bits, signed.
  - ACCUM:
    - acc <= acc + sext(hp); acc is IN_W+2+LOG2D bits.
    - If cnt == DECIM-1: compute avg = (acc+hp) >>> LOG2D and y = avg >>> (IN_W-N); clear acc and cnt.
    - Otherwise cnt <= cnt+1.
- Output registers load on the ACCUM->IDLE edge when a decimation completed, so sampleValid is high in the following cycle:
  - sampleOut = sat_N(y): clamp to [-2^(N-1), 2^(N-1)-1].
  - clipped = 1 iff clamping occurred.
  - peakAbs = |sampleOut| >> (N-10); -2^(N-1) maps to 512, so the result always fits in 10 bits.
  - sampleOut and peakAbs hold their values between pulses.
- Throughput: with readReady held high, doRead pulses every 4 cycles and sampleValid pulses every 4*DECIM cycles.
- Latency: READ to sampleValid is 3 cycles for the final sample of a group.
- readReady is sampled only in IDLE. A drop in readReady during READ/FILT/ACCUM is ignored; the latched pair is processed.
- No doRead is issued unless readReady=1 was seen in IDLE.
- DECIM=1: every input produces an output; the count logic degenerates.
- Arithmetic shifts everywhere; no rounding, truncation toward -inf.
- If rst asserts mid-sequence, the in-flight sample and partial accumulation are discarded. After release, the first output requires DECIM fresh samples.

Test Plan:
- Idle: DECIM=2, readReady=0 for 100 cycles -> doRead and sampleValid stay 0; all outputs 0.
- Streaming zeros: DECIM=2, readReady=1 constant, L=R=0 -> doRead pulses every 4 cycles; sampleValid every 8 cycles; sampleOut=0, peakAbs=0, clipped=0.
- DC removal: DECIM=1, DC_SHIFT=4, L=R=0x000100 constant (mono 512) -> first sampleOut=2, second=1; subsequent outputs decay monotonically to 0 and remain 0.
- Saturation: DECIM=1, DC_SHIFT=20, L=R=0x7FFFFF -> first sampleOut=32767, clipped=1, peakAbs=511. Repeat with L=R=0x800000 -> sampleOut=-32768, clipped=1, peakAbs=512.
- Averaging: DECIM=4, DC_SHIFT=20, L=R alternating 0x000200/0x000600 (mono 1024/3072) -> first sampleOut=8, clipped=0, sampleValid after the 4th doRead.
- Reset mid-operation: DECIM=2, assert rst during FILT of the 2nd sample -> outputs go to 0 without waiting for a clock edge. After release, sampleValid pulses only after 2 new doRead strobes.
